// File: rtl/instr_fetch.sv
// Variable-length (1 or 2 byte) instruction fetch unit: owns the PC, reads bytes from
// instruction memory one at a time and presents assembled 16-bit words to control.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] seq_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    F0  = 2'd0,
    F1  = 2'd1,
    OUT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        byte0;
  logic              bubble;
  logic [15:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [ADDR_W-1:0] seq_pc_q;

  // Handshake: instr/instr_pc/seq_pc are held stable while instr_valid=1 and transfer
  // on the rising edge where instr_valid && instr_ready are both high.
  // bubble marks the single idle cycle after a redirect, when no request is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= F0;
      pc         <= RESET_PC;
      byte0      <= 8'h00;
      bubble     <= 1'b0;
      instr_q    <= 16'h0000;
      instr_pc_q <= '0;
      seq_pc_q   <= '0;
    end else if (redirect) begin
      state  <= F0;
      pc     <= redirect_pc;
      bubble <= 1'b1;
    end else begin
      bubble <= 1'b0;
      case (state)
        F0: begin
          if (!bubble && mem_valid) begin
            byte0 <= mem_rdata;
            if (mem_rdata[7:6] == 2'b11) begin
              state <= F1;
            end else begin
              state      <= OUT;
              instr_q    <= {8'h00, mem_rdata};
              instr_pc_q <= pc;
              seq_pc_q   <= pc + ONE;
            end
          end
        end
        F1: begin
          if (mem_valid) begin
            state      <= OUT;
            instr_q    <= {mem_rdata, byte0};
            instr_pc_q <= pc;
            seq_pc_q   <= pc + TWO;
          end
        end
        OUT: begin
          if (instr_ready) begin
            state <= F0;
            pc    <= seq_pc_q;
          end
        end
        default: state <= F0;
      endcase
    end
  end

  // Request is withheld while reset is asserted so memory never sees a fetch from a dying PC.
  assign mem_req     = !reset && (((state == F0) && !bubble) || (state == F1));
  assign mem_addr    = (state == F1) ? (pc + ONE) : pc;
  assign instr_valid = (state == OUT);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign seq_pc      = seq_pc_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (RESET_PC 00 and FF), behavioural byte memories,
// per-instance expected queues popped by monitors on each handshake.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, reset_b;
  logic        ready, ready_b;
  logic        stall, stall_b;
  logic        redirect, redirect_b;
  logic [7:0]  redirect_pc, redirect_pc_b;

  logic        mem_req, mem_req_b;
  logic [7:0]  mem_addr, mem_addr_b;
  logic [7:0]  mem_rdata, mem_rdata_b;
  logic        mem_valid, mem_valid_b;
  logic [15:0] instr, instr_b;
  logic        instr_valid, instr_valid_b;
  logic [7:0]  instr_pc, instr_pc_b;
  logic [7:0]  seq_pc, seq_pc_b;
  logic [1:0]  state, state_b;

  logic [7:0]  mem   [256];
  logic [7:0]  mem_b [256];

  logic [31:0] exp_q[$];
  logic [31:0] exp_q_b[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(ready), .instr_pc(instr_pc),
    .seq_pc(seq_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .state_dbg(state)
  );

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'hFF)) dut_b (
    .clk(clk), .reset(reset_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_rdata(mem_rdata_b), .mem_valid(mem_valid_b), .instr(instr_b),
    .instr_valid(instr_valid_b), .instr_ready(ready_b), .instr_pc(instr_pc_b),
    .seq_pc(seq_pc_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
    .state_dbg(state_b)
  );

  // Zero-wait memories unless stalled.
  always_comb begin
    mem_rdata   = mem[mem_addr];
    mem_valid   = mem_req && !stall;
    mem_rdata_b = mem_b[mem_addr_b];
    mem_valid_b = mem_req_b && !stall_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: {instr, instr_pc, seq_pc} compared at every handshake.
  always @(negedge clk) begin
    if (instr_valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_a unexpected: got %h expected none", {instr, instr_pc, seq_pc});
      end else begin
        check("sb_a", {instr, instr_pc, seq_pc}, exp_q.pop_front());
      end
    end
    if (instr_valid_b && ready_b) begin
      if (exp_q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_b unexpected: got %h expected none", {instr_b, instr_pc_b, seq_pc_b});
      end else begin
        check("sb_b", {instr_b, instr_pc_b, seq_pc_b}, exp_q_b.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    ready = 1'b1; ready_b = 1'b1;
    stall = 1'b0; stall_b = 1'b0;
    redirect = 1'b0; redirect_b = 1'b0;
    redirect_pc = 8'h00; redirect_pc_b = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem[8'h00] = 8'h05;
    mem[8'h01] = 8'hE9; mem[8'h02] = 8'h3C;
    mem[8'h03] = 8'hC1; mem[8'h04] = 8'h77;
    mem[8'h05] = 8'hD0; mem[8'h06] = 8'hAA;
    mem[8'h40] = 8'h21; mem[8'h41] = 8'h0A;
    mem[8'h80] = 8'h01;
    mem_b[8'hFF] = 8'hF8; mem_b[8'h00] = 8'h12;
    mem_b[8'h01] = 8'hC5;

    repeat (2) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_instr_pc", {24'd0, instr_pc}, 32'd0);
    check("rst_seq_pc", {24'd0, seq_pc}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);

    // 1-byte instruction right after reset
    exp_q.push_back({16'h0005, 8'h00, 8'h01});
    reset = 1'b0;
    #1;
    check("t1_req", {31'd0, mem_req}, 32'd1);
    check("t1_addr", {24'd0, mem_addr}, 32'h00);
    tick();
    check("t1_valid_lat", {31'd0, instr_valid}, 32'd1);
    check("t1_instr", {16'd0, instr}, 32'h0005);
    tick();
    check("t1_next_addr", {24'd0, mem_addr}, 32'h01);

    // 2-byte instruction, then held by ready=0
    ready = 1'b0;
    exp_q.push_back({16'h3CE9, 8'h01, 8'h03});
    tick();
    check("t2_addr_f1", {24'd0, mem_addr}, 32'h02);
    tick();
    check("t2_valid_lat", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_valid", {31'd0, instr_valid}, 32'd1);
      check("t3_hold_instr", {16'd0, instr}, 32'h3CE9);
      check("t3_hold_pc", {24'd0, instr_pc}, 32'h01);
      check("t3_hold_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    ready = 1'b1;
    tick();
    check("t3_adv_addr", {24'd0, mem_addr}, 32'h03);

    // Wait states in F1
    exp_q.push_back({16'h77C1, 8'h03, 8'h05});
    tick();
    check("t4_addr_f1", {24'd0, mem_addr}, 32'h04);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_stall_req", {31'd0, mem_req}, 32'd1);
      check("t4_stall_addr", {24'd0, mem_addr}, 32'h04);
      check("t4_stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("t4_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    check("t4_next_addr", {24'd0, mem_addr}, 32'h05);

    // Redirect during F1: stale second byte discarded
    tick();
    check("t5_addr_f1", {24'd0, mem_addr}, 32'h06);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    #1;
    check("t5_bubble_req", {31'd0, mem_req}, 32'd0);
    check("t5_bubble_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_bubble_state", {30'd0, state}, 32'd0);
    exp_q.push_back({16'h0021, 8'h40, 8'h41});
    tick();
    check("t5_req", {31'd0, mem_req}, 32'd1);
    check("t5_addr", {24'd0, mem_addr}, 32'h40);
    tick();
    check("t5_instr", {16'd0, instr}, 32'h0021);
    tick();
    check("t5_next_addr", {24'd0, mem_addr}, 32'h41);

    // Redirect coinciding with a handshake
    exp_q.push_back({16'h000A, 8'h41, 8'h42});
    tick();
    check("t5b_valid", {31'd0, instr_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect = 1'b0;
    #1;
    check("t5b_bubble_req", {31'd0, mem_req}, 32'd0);
    check("t5b_bubble_valid", {31'd0, instr_valid}, 32'd0);
    exp_q.push_back({16'h0001, 8'h80, 8'h81});
    tick();
    check("t5b_addr", {24'd0, mem_addr}, 32'h80);
    tick();
    check("t5b_valid2", {31'd0, instr_valid}, 32'd1);
    reset = 1'b1;
    tick();

    // Wrap-around with RESET_PC=FF, then reset mid-F1
    exp_q_b.push_back({16'h12F8, 8'hFF, 8'h01});
    reset_b = 1'b0;
    #1;
    check("t6_req", {31'd0, mem_req_b}, 32'd1);
    check("t6_addr", {24'd0, mem_addr_b}, 32'hFF);
    tick();
    check("t6_wrap_addr", {24'd0, mem_addr_b}, 32'h00);
    tick();
    check("t6_valid", {31'd0, instr_valid_b}, 32'd1);
    check("t6_seq_pc", {24'd0, seq_pc_b}, 32'h01);
    tick();
    check("t6_next_addr", {24'd0, mem_addr_b}, 32'h01);
    tick();
    check("t6_f1_addr", {24'd0, mem_addr_b}, 32'h02);
    check("t6_f1_state", {30'd0, state_b}, 32'd1);
    reset_b = 1'b1;
    tick();
    check("t6_rst_state", {30'd0, state_b}, 32'd0);
    check("t6_rst_valid", {31'd0, instr_valid_b}, 32'd0);
    check("t6_rst_instr", {16'd0, instr_b}, 32'd0);
    check("t6_rst_instr_pc", {24'd0, instr_pc_b}, 32'd0);
    check("t6_rst_seq_pc", {24'd0, seq_pc_b}, 32'd0);
    check("t6_rst_req", {31'd0, mem_req_b}, 32'd0);
    reset_b = 1'b0;
    #1;
    check("t6_rst_addr", {24'd0, mem_addr_b}, 32'hFF);
    reset_b = 1'b1;
    repeat (2) tick();

    check("sb_a_drained", exp_q.size(), 32'd0);
    check("sb_b_drained", exp_q_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
